vend_ctrl_param: RTL
====================

// Module: vend_ctrl_param
// PURPOSE
//   Parametrised Mealy vending controller; next generation of the 4-state 5/10 vend FSM.
//   Accumulates coin credit up to a configurable PRICE and adds a third coin denomination.
//   Returns any amount of change as a train of chg5 pulses and exposes credit and busy status.
//   Sits between the coin acceptor decoder and the dispense/change-hopper drivers.
// PARAMETERS
//   PRICE      20  item price, in currency units; multiple of COIN_UNIT, > 0
//   COIN_UNIT   5  change-hopper denomination; one chg5 pulse returns COIN_UNIT
//   COIN1_VAL   5  value of coin code 2'b01 (multiple of COIN_UNIT)
//   COIN2_VAL  10  value of coin code 2'b10 (multiple of COIN_UNIT)
//   COIN3_VAL  25  value of coin code 2'b11 (multiple of COIN_UNIT)
//   CREDIT_W    6  credit width; must hold PRICE-COIN_UNIT+max(COINx_VAL)
// PORTS
//   clk          in   1         single clock, all state on posedge
//   rst          in   1         synchronous, active-high reset
//   coin         in   2         00 none, 01/10/11 = COIN1/2/3; one coin per cycle
//   cancel       in   1         refund request (functional only with VEND_CANCEL_EN)
//   dispense     out  1         Mealy, 1-cycle vend pulse
//   chg5         out  1         one pulse = COIN_UNIT returned
//   coin_reject  out  1         Mealy, coin presented while busy; coin is not credited
//   busy         out  1         registered, high while change pulses are pending
//   credit       out  CREDIT_W  registered current credit
// BEHAVIOUR
//   States: IDLE (credit=0), COLLECT (0<credit<PRICE), CHANGE (draining change counter).
//   Reset: state=IDLE, credit=0, change counter=0, busy=0.
//   While rst=1, dispense/chg5/coin_reject are forced to 0.
//   IDLE/COLLECT: sum = credit + coin value (0 for 00), computed at CREDIT_W+1 bits.
//     sum<PRICE: credit<=sum; state<=IDLE if sum==0, else COLLECT; no outputs.
//     sum>=PRICE: dispense=1 same cycle; chg = sum-PRICE; credit<=0.
//       chg>=COIN_UNIT: chg5=1 same cycle, counter<=chg/COIN_UNIT-1.
//       Next state is CHANGE if counter>0, else IDLE.
//       chg==0: chg5=0, next state IDLE.
//   CHANGE: chg5=1 every cycle; counter decrements; counter==1 -> next state IDLE.
//     busy=1 for exactly the cycles spent in CHANGE.
//     Nonzero coin -> coin_reject=1 same cycle; credit stays 0; cancel is ignored.
//   coin 00 in IDLE/COLLECT: credit held, no outputs.
//   Reset during CHANGE: pending change is discarded; no further chg5 pulses.
//   Latency: dispense and the first chg5 are combinational from coin.
//     Each further chg5 follows at one per cycle.
// CONFIGURATION
//   VEND_CANCEL_EN defined:
//     cancel=1 in COLLECT, or in IDLE with a nonzero coin: refund r = credit + coin value.
//     Cancel beats vend: no dispense even if r>=PRICE.
//     First chg5 fires the same cycle; counter<=r/COIN_UNIT-1; drained via CHANGE as above.
//   VEND_CANCEL_EN undefined: cancel port present but ignored; no refund path is synthesised.
// STRUCTURE
//   Shared package vend_pkg: state encoding (IDLE/COLLECT/CHANGE), coin code constants,
//     and a coin-value decode function taking the COINx_VAL parameters.
//   Sub-module vend_change_ctr: loadable down-counter, width $clog2 of max change pulses.
//     Ports: load, load_val, pulse, busy.
//   Top holds the credit register, the FSM, and the Mealy output logic.
// TESTING (defaults: PRICE=20, coins 5/10/25, unit 5)
//   10,10 -> dispense on 2nd coin cycle; chg5=0; credit 10 then 0; busy stays 0.
//   5,10,10 -> dispense=1 and chg5=1 in the same cycle; next cycle busy=0, credit=0.
//   10 then 25 (change 15) -> dispense+chg5 at cycle 0; chg5 at cycles 1,2; busy at 1-2.
//     Coin 01 at cycle 1 -> coin_reject=1 and credit stays 0.
//   coin 00 for 10 cycles with credit=15 -> credit holds 15; no output pulses.
//   VEND_CANCEL_EN, credit 15, cancel -> chg5 at cycles 0,1,2; dispense=0; credit=0.
//     Same stimulus without the macro -> no chg5, credit stays 15.
//   Reset asserted at cycle 1 of a 3-pulse change -> chg5=0 while rst=1.
//     After release: busy=0, credit=0, state IDLE.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared definitions for the parametrised vending controller:
// FSM state encoding, coin codes and the coin-value decode.
package vend_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_CHANGE  = 2'd2;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_1    = 2'b01;
  localparam logic [1:0] COIN_2    = 2'b10;
  localparam logic [1:0] COIN_3    = 2'b11;

  function automatic int unsigned coin_value(
    input logic [1:0]  c,
    input int unsigned v1,
    input int unsigned v2,
    input int unsigned v3
  );
    case (c)
      COIN_1:  return v1;
      COIN_2:  return v2;
      COIN_3:  return v3;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/vend_change_ctr.sv
// Loadable down-counter holding the change pulses still owed
// after the current cycle.
module vend_change_ctr #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         pulse,
  output logic         last,
  output logic         busy
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (cnt != '0)
      cnt <= cnt - W'(1);
  end

  assign busy  = (cnt != '0);
  assign pulse = busy;
  assign last  = (cnt == W'(1));

endmodule

// File: rtl/vend_ctrl_param.sv
// Parametrised Mealy vending controller with change train output.
// Optional refund path enabled by defining VEND_CANCEL_EN.
module vend_ctrl_param
  import vend_pkg::*;
#(
  parameter int unsigned PRICE     = 20,
  parameter int unsigned COIN_UNIT = 5,
  parameter int unsigned COIN1_VAL = 5,
  parameter int unsigned COIN2_VAL = 10,
  parameter int unsigned COIN3_VAL = 25,
  parameter int unsigned CREDIT_W  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          coin,
  input  logic                cancel,
  output logic                dispense,
  output logic                chg5,
  output logic                coin_reject,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit
);

  localparam int unsigned MAX12 =
    (COIN1_VAL > COIN2_VAL) ? COIN1_VAL : COIN2_VAL;
  localparam int unsigned MAXC =
    (MAX12 > COIN3_VAL) ? MAX12 : COIN3_VAL;
  // worst case is a full refund, which exceeds any vend change
  localparam int unsigned MAXP = (PRICE + MAXC) / COIN_UNIT;
  localparam int unsigned CW   = $clog2(MAXP + 1);
  localparam int unsigned SW   = CREDIT_W + 1;

  localparam logic [SW-1:0] PRICE_S = SW'(PRICE);
  localparam logic [SW-1:0] UNIT_S  = SW'(COIN_UNIT);
  localparam logic [SW-1:0] ONE_S   = SW'(1);

  logic [1:0]          state;
  logic [1:0]          state_nx;
  logic [CREDIT_W-1:0] credit_nx;
  logic [SW-1:0]       cval;
  logic [SW-1:0]       sum;
  logic [SW-1:0]       chg;
  logic                refund;
  logic                load;
  logic [CW-1:0]       load_val;
  logic                ctr_pulse;
  logic                ctr_last;
  logic                ctr_busy;
  logic                disp_c;
  logic                chg_c;
  logic                rej_c;

`ifdef VEND_CANCEL_EN
  assign refund = cancel &&
    ((state == ST_COLLECT) || (coin != COIN_NONE));
`else
  logic unused_cancel;
  assign unused_cancel = cancel;
  assign refund = 1'b0;
`endif

  assign cval = SW'(coin_value(coin, COIN1_VAL, COIN2_VAL, COIN3_VAL));
  assign sum  = {1'b0, credit} + cval;
  assign chg  = sum - PRICE_S;

  always_comb begin
    state_nx  = state;
    credit_nx = credit;
    load      = 1'b0;
    load_val  = '0;
    disp_c    = 1'b0;
    chg_c     = 1'b0;
    rej_c     = 1'b0;
    unique case (state)
      ST_IDLE, ST_COLLECT: begin
        if (refund) begin
          // refund wins over vend even when sum reaches PRICE
          chg_c     = 1'b1;
          load      = 1'b1;
          load_val  = CW'((sum / UNIT_S) - ONE_S);
          credit_nx = '0;
          state_nx  = (load_val != '0) ? ST_CHANGE : ST_IDLE;
        end else if (sum >= PRICE_S) begin
          disp_c    = 1'b1;
          credit_nx = '0;
          state_nx  = ST_IDLE;
          if (chg >= UNIT_S) begin
            chg_c    = 1'b1;
            load     = 1'b1;
            load_val = CW'((chg / UNIT_S) - ONE_S);
            if (load_val != '0)
              state_nx = ST_CHANGE;
          end
        end else begin
          credit_nx = CREDIT_W'(sum);
          state_nx  = (sum == '0) ? ST_IDLE : ST_COLLECT;
        end
      end
      ST_CHANGE: begin
        chg_c = ctr_pulse;
        rej_c = (coin != COIN_NONE);
        if (ctr_last)
          state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      credit <= '0;
    end else begin
      state  <= state_nx;
      credit <= credit_nx;
    end
  end

  vend_change_ctr #(.W(CW)) u_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .pulse    (ctr_pulse),
    .last     (ctr_last),
    .busy     (ctr_busy)
  );

  assign dispense    = disp_c & ~rst;
  assign chg5        = chg_c & ~rst;
  assign coin_reject = rej_c & ~rst;
  assign busy        = ctr_busy;

endmodule
